fir_output_formatter: RTL and testbench

- Sits directly downstream of the 63-tap FIR filter block and consumes its 32-bit accumulated output on the same sample strobe (ena) that drives the filter.
- Rescales each filter result by the coefficient fraction width, rounds it, and saturates it to a 16-bit sample.
- Buffers the samples in a small FIFO and presents them on a valid/ready stream toward the DAC/packetiser side.
- Keeps saturation and overflow statistics for debug.

---
 rtl/fir_output_formatter.sv | 137 +++++++++++++
 tb/tb_fir_output_formatter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_formatter.sv
// Rescales, rounds and saturates the FIR accumulator output to a 16-bit sample,
// queues it in a show-ahead FIFO and streams it out on valid/ready with debug counters.
module fir_output_formatter #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 10,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic signed [0:IN_W-1]        y_in,
    input  logic                          clr_stats,
    output logic signed [0:OUT_W-1]       m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(DEPTH):0]        fill,
    output logic [CNT_W-1:0]              sat_cnt,
    output logic [CNT_W-1:0]              ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned EW = IN_W + 1;

    localparam logic signed [EW-1:0] ROUND = EW'(1) <<< (SHIFT - 1);
    localparam logic signed [EW-1:0] MAX_V = (EW'(1) <<< (OUT_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MIN_V = -(EW'(1) <<< (OUT_W - 1));

    logic signed [IN_W-1:0] y_c;
    logic signed [EW-1:0]   ext_c;
    logic signed [EW-1:0]   sum_c;
    logic signed [EW-1:0]   shr_c;
    logic                   hi_c;
    logic                   lo_c;
    logic                   clip_c;
    logic [OUT_W-1:0]       sample_c;

    logic                   ena_d;
    logic                   fmt_v;
    logic [OUT_W-1:0]       fmt_data;

    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [FW-1:0]          fill_nxt;
    logic                   pop_c;
    logic                   full_c;
    logic                   push_c;
    logic                   drop_c;

    // Round half-up, arithmetic shift, then clip to the output range.
    assign y_c      = y_in;
    assign ext_c    = {y_c[IN_W-1], y_c};
    assign sum_c    = ext_c + ROUND;
    assign shr_c    = sum_c >>> SHIFT;
    assign hi_c     = shr_c > MAX_V;
    assign lo_c     = shr_c < MIN_V;
    assign clip_c   = hi_c | lo_c;
    assign sample_c = hi_c ? MAX_V[OUT_W-1:0] :
                      lo_c ? MIN_V[OUT_W-1:0] : shr_c[OUT_W-1:0];

    assign pop_c  = m_valid & m_ready;
    assign full_c = (fill == FW'(DEPTH));
    assign push_c = fmt_v & (~full_c | pop_c);
    assign drop_c = fmt_v & full_c & ~pop_c;

    always_comb begin
        fill_nxt = fill;
        if (push_c && !pop_c) begin
            fill_nxt = fill + FW'(1);
        end else if (!push_c && pop_c) begin
            fill_nxt = fill - FW'(1);
        end
    end

    // Filter output is valid one edge after its strobe, hence the ena_d alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_d    <= 1'b0;
            fmt_v    <= 1'b0;
            fmt_data <= '0;
        end else begin
            ena_d <= ena;
            fmt_v <= ena_d;
            if (ena_d) begin
                fmt_data <= sample_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            m_valid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fill    <= fill_nxt;
            m_valid <= (fill_nxt != '0);
        end
    end

    // Storage needs no reset: it is only observed through m_valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= fmt_data;
        end
    end

    assign m_data = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
            ovf_cnt <= '0;
        end else if (clr_stats) begin
            sat_cnt <= '0;
            ovf_cnt <= '0;
        end else begin
            if (ena_d && clip_c && (sat_cnt != '1)) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
            if (drop_c && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_output_formatter.sv
// Scoreboard bench for fir_output_formatter: stimulus queues expected samples,
// a negedge monitor pops and compares every accepted output word.
module tb_fir_output_formatter;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic signed [0:31] y_in;
    logic               clr_stats;
    logic signed [0:15] m_data;
    logic               m_valid;
    logic               m_ready;
    logic [3:0]         fill;
    logic [15:0]        sat_cnt;
    logic [15:0]        ovf_cnt;

    logic signed [15:0] data_s;
    int                 total  = 0;
    int                 passed = 0;
    int                 exp_q[$];
    int                 mon_exp;

    fir_output_formatter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .y_in      (y_in),
        .clr_stats (clr_stats),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fill      (fill),
        .sat_cnt   (sat_cnt),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;
    assign data_s = m_data;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: every word the sink accepts must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", int'(data_s), -99999);
            end else begin
                mon_exp = exp_q.pop_front();
                check("stream_data", int'(data_s), mon_exp);
            end
        end
    end

    // One-cycle strobe; y_in follows one cycle later like the filter output.
    task automatic strobe(input int v, input bit lat);
        @(posedge clk); #1;
        ena = 1'b1;
        @(posedge clk); #1;          // t0 has passed
        ena  = 1'b0;
        y_in = v;
        @(posedge clk); #1;          // t1
        if (lat) check("latency_t1_valid", int'(m_valid), 0);
        @(posedge clk); #1;          // t2
        if (lat) check("latency_t2_valid", int'(m_valid), 1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        check(name, exp_q.size(), 0);
        @(posedge clk); #1;
        check({name, "_valid_low"}, int'(m_valid), 0);
        check({name, "_data_zero"}, int'(data_s), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; y_in = '0; clr_stats = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_valid", int'(m_valid), 0);
        check("reset_fill", int'(fill), 0);
        check("reset_sat", int'(sat_cnt), 0);
        check("reset_ovf", int'(ovf_cnt), 0);
        check("reset_data", int'(data_s), 0);

        // Basic rounding: 5000 -> 5, 1536 -> 2, -1536 -> -1
        exp_q.push_back(5);  strobe(5000, 1'b1);
        exp_q.push_back(2);  strobe(1536, 1'b1);
        exp_q.push_back(-1); strobe(-1536, 1'b1);
        drain("basic_drain");
        check("basic_sat", int'(sat_cnt), 0);

        // Saturation both ways, then clear
        exp_q.push_back(32767);  strobe(32'h7FFF_FFFF, 1'b1);
        exp_q.push_back(-32768); strobe(32'h8000_0000, 1'b1);
        drain("sat_drain");
        check("sat_cnt_two", int'(sat_cnt), 2);
        @(posedge clk); #1 clr_stats = 1'b1;
        @(posedge clk); #1 clr_stats = 1'b0;
        check("sat_cnt_cleared", int'(sat_cnt), 0);

        // Backpressure: 10 strobes into an 8-deep FIFO, last two dropped
        m_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) exp_q.push_back(k);
            strobe(k * 1024, 1'b0);
        end
        repeat (2) @(posedge clk); #1;
        check("bp_fill_full", int'(fill), 8);
        check("bp_ovf", int'(ovf_cnt), 2);
        check("bp_valid", int'(m_valid), 1);
        check("bp_head", int'(data_s), 1);
        @(posedge clk); #1;
        check("bp_head_stable", int'(data_s), 1);

        // Full FIFO: push and pop on the same edge
        exp_q.push_back(11);
        @(posedge clk); #1 ena = 1'b1;
        @(posedge clk); #1 ena = 1'b0; y_in = 11 * 1024;
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        check("full_pushpop_fill", int'(fill), 8);
        check("full_pushpop_ovf", int'(ovf_cnt), 2);
        check("full_pushpop_head", int'(data_s), 2);
        m_ready = 1'b1;
        drain("bp_drain");
        check("bp_fill_empty", int'(fill), 0);

        // Continuous streaming ramp
        begin
            int n_words;
            int vc;
            int maxf;
            bit seen;
            bit ended;
            bit gap;
            n_words = 12; vc = 0; maxf = 0; seen = 0; ended = 0; gap = 0;
            fork
                for (int i = 0; i <= n_words; i++) begin
                    @(posedge clk); #1;
                    ena  = (i < n_words);
                    y_in = (i >= 1) ? i * 1024 : 0;
                    if (i < n_words) exp_q.push_back(i + 1);
                end
                for (int c = 0; c < n_words + 6; c++) begin
                    @(negedge clk);
                    if (m_valid) begin
                        if (ended) gap = 1'b1;
                        seen = 1'b1;
                        vc++;
                    end else if (seen) begin
                        ended = 1'b1;
                    end
                    if (int'(fill) > maxf) maxf = int'(fill);
                end
            join
            check("stream_word_count", vc, n_words);
            check("stream_no_gap", int'(gap), 0);
            check("stream_fill_le2", int'(maxf <= 2), 1);
        end
        drain("stream_drain");

        // Asynchronous reset with queued words
        m_ready = 1'b0;
        strobe(32'h7FFF_FFFF, 1'b0);
        strobe(32'h7FFF_FFFF, 1'b0);
        strobe(32'h7FFF_FFFF, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("pre_reset_fill", int'(fill), 3);
        check("pre_reset_sat", int'(sat_cnt), 3);
        check("pre_reset_ovf", int'(ovf_cnt), 2);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", int'(m_valid), 0);
        check("async_reset_fill", int'(fill), 0);
        check("async_reset_sat", int'(sat_cnt), 0);
        check("async_reset_ovf", int'(ovf_cnt), 0);
        check("async_reset_data", int'(data_s), 0);
        @(posedge clk); #3 rst_n = 1'b1; m_ready = 1'b1;
        begin
            int vq;
            vq = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (m_valid) vq++;
            end
            check("post_reset_quiet", vq, 0);
        end
        exp_q.push_back(-2);
        strobe(-2048, 1'b1);
        drain("post_reset_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
